cacheline_adapter: RTL and testbench

- Bridges the cache's 256-bit cacheline port (dfp_*) to the 64-bit burst memory port (bmem_*).
- The bmem port is the port the top-level bench memory model responds on.
- Read misses: the block issues one burst read request, collects 4 beats, then returns one full line.
- Writebacks: the block drives 4 write beats, then acknowledges the cache.
- Sits between the L1 caches/arbiter and the bmem boundary of dut.

---
 rtl/cacheline_adapter_if.sv | 39 +++
 rtl/cacheline_adapter.sv | 185 ++++++++++++++++++
 tb/tb_cacheline_adapter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
// Bus bundle between a cacheline-wide requester (dfp_*) and a beat-wide burst memory (bmem_*).
// The adapter connects through the slave modport; the requester/memory side uses master.
interface cacheline_adapter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4
);
    localparam int LINE_W = BEAT_WIDTH * BEATS;

    logic [ADDR_WIDTH-1:0] dfp_addr;
    logic                  dfp_read;
    logic                  dfp_write;
    logic [LINE_W-1:0]     dfp_wdata;
    logic [LINE_W-1:0]     dfp_rdata;
    logic                  dfp_resp;

    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns cacheline reads/writebacks into 4-beat bursts on the bmem port.
// Build macro CLADAPT_STATS_EN adds rd_lines/wr_lines counters and a stray read-beat check.
`ifdef CLADAPT_STATS_EN
module cacheline_adapter_chk #(
    parameter int ADDR_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  in_rd_data,
    input logic                  rvalid,
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic [ADDR_WIDTH-1:0] addr
);
    // Report read beats tagged for another line while a burst is being collected.
    always_ff @(posedge clk) begin
        assert (rst || !(in_rd_data && rvalid && (raddr != addr)))
            else $error("cacheline_adapter: rvalid raddr %h while collecting line %h", raddr, addr);
    end
endmodule
`endif

module cacheline_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4
) (
    input logic                clk,
    input logic                rst,
    cacheline_adapter_if.slave bus
`ifdef CLADAPT_STATS_EN
    ,
    output logic [31:0]        rd_lines,
    output logic [31:0]        wr_lines
`endif
);
    localparam int LINE_W = BEAT_WIDTH * BEATS;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_REQ   = 3'd1;
    localparam logic [2:0] RD_DATA  = 3'd2;
    localparam logic [2:0] WR_BURST = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]            state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s, addr_align_s;
    logic [LINE_W-1:0]     line_r, line_s;
    logic [LINE_W-1:0]     rdata_r, rdata_s;
    logic                  resp_r, bmem_read_r, bmem_write_r;
    logic [ADDR_WIDTH-1:0] bmem_addr_r;
    logic [BEAT_WIDTH-1:0] bmem_wdata_r;
    logic                  beat_hit_s;

    assign addr_align_s = {bus.dfp_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    // Only beats tagged with the line being collected are accepted; stale bursts fall through.
    assign beat_hit_s   = bus.bmem_rvalid && (bus.bmem_raddr == addr_r);

    // Next-state, beat counter and line buffer update.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        line_s  = line_r;
        rdata_s = rdata_r;
        case (state_r)
            IDLE: begin
                if (bus.dfp_write) begin
                    state_s = WR_BURST;
                    addr_s  = addr_align_s;
                    line_s  = bus.dfp_wdata;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (bus.dfp_read) begin
                    state_s = RD_REQ;
                    addr_s  = addr_align_s;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (bus.bmem_ready) begin
                    state_s = RD_DATA;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_DATA: begin
                if (beat_hit_s) begin
                    line_s[cnt_r*BEAT_WIDTH +: BEAT_WIDTH] = bus.bmem_rdata;
                    cnt_s = cnt_r + 1'b1;
                    if (cnt_r == LAST_BEAT) begin
                        state_s = RESP;
                        rdata_s = line_s;
                    end else begin
                        state_s = RD_DATA;
                    end
                end else begin
                    state_s = RD_DATA;
                end
            end
            WR_BURST: begin
                if (bus.bmem_ready) begin
                    cnt_s = cnt_r + 1'b1;
                    if (cnt_r == LAST_BEAT) begin
                        state_s = RESP;
                    end else begin
                        state_s = WR_BURST;
                    end
                end else begin
                    state_s = WR_BURST;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State registers plus outputs registered from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            addr_r       <= {ADDR_WIDTH{1'b0}};
            line_r       <= {LINE_W{1'b0}};
            rdata_r      <= {LINE_W{1'b0}};
            resp_r       <= 1'b0;
            bmem_read_r  <= 1'b0;
            bmem_write_r <= 1'b0;
            bmem_addr_r  <= {ADDR_WIDTH{1'b0}};
            bmem_wdata_r <= {BEAT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            addr_r       <= addr_s;
            line_r       <= line_s;
            rdata_r      <= rdata_s;
            resp_r       <= (state_s == RESP);
            bmem_read_r  <= (state_s == RD_REQ);
            bmem_write_r <= (state_s == WR_BURST);
            bmem_addr_r  <= (state_s != IDLE) ? addr_s : {ADDR_WIDTH{1'b0}};
            bmem_wdata_r <= (state_s == WR_BURST) ? line_s[cnt_s*BEAT_WIDTH +: BEAT_WIDTH]
                                                  : {BEAT_WIDTH{1'b0}};
        end
    end

    assign bus.dfp_rdata  = rdata_r;
    assign bus.dfp_resp   = resp_r;
    assign bus.bmem_addr  = bmem_addr_r;
    assign bus.bmem_read  = bmem_read_r;
    assign bus.bmem_write = bmem_write_r;
    assign bus.bmem_wdata = bmem_wdata_r;

`ifdef CLADAPT_STATS_EN
    // Completed-line counters; RESP is only ever entered from RD_DATA or WR_BURST.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lines <= 32'd0;
            wr_lines <= 32'd0;
        end else if (state_s == RESP) begin
            if (state_r == WR_BURST) begin
                wr_lines <= wr_lines + 32'd1;
            end else begin
                rd_lines <= rd_lines + 32'd1;
            end
        end
    end

    cacheline_adapter_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .in_rd_data (state_r == RD_DATA),
        .rvalid     (bus.bmem_rvalid),
        .raddr      (bus.bmem_raddr),
        .addr       (addr_r)
    );
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: a cycle-driven requester/memory responder with
// scoreboard queues for expected read lines and expected write beats.
module tb_cacheline_adapter;
    localparam int AW = 32;
    localparam int BW = 64;
    localparam int NB = 4;
    localparam int LW = BW * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cacheline_adapter_if #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS(NB)) bus ();
`ifdef CLADAPT_STATS_EN
    logic [31:0] rd_lines, wr_lines;
`endif

    cacheline_adapter #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CLADAPT_STATS_EN
        ,
        .rd_lines (rd_lines),
        .wr_lines (wr_lines)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [LW-1:0] exp_lines[$];
    logic [BW-1:0] exp_beats[$];

    int            resp_cyc[$];
    logic [LW-1:0] resp_line[$];
    logic [BW-1:0] wbeats[$];
    int            rd_cycles, first_rd, first_wr, extra_resp;
    logic [AW-1:0] req_addr;
    bit            wr_on_resp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the cache (dropping requests after dfp_resp) and the burst memory; records events only.
    task automatic serve(input int n_resp, input int stall, input int gap_at, input int gap_len,
                         input logic [15:0] rpat, input int rpat_len, input logic [LW-1:0] rline,
                         input bit bad_in_gap);
        int cyc = 0;
        int beat = 0;
        int widx = 0;
        int stall_left = stall;
        int gap_left = gap_len;
        bit acc = 1'b0;
        resp_cyc.delete(); resp_line.delete(); wbeats.delete();
        rd_cycles = 0; first_rd = -1; first_wr = -1; extra_resp = 0; wr_on_resp = 1'b0;
        req_addr = '0;
        while (resp_cyc.size() < n_resp && cyc < 300) begin
            tick();
            cyc++;
            bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
            bus.bmem_rdata = '0;   bus.bmem_raddr = '0;
            if (bus.dfp_resp === 1'b1) begin
                resp_cyc.push_back(cyc);
                resp_line.push_back(bus.dfp_rdata);
                if (bus.bmem_write === 1'b1) wr_on_resp = 1'b1;
                if (bus.dfp_write) bus.dfp_write = 1'b0;
                else bus.dfp_read = 1'b0;
            end
            if (bus.bmem_read === 1'b1) begin
                rd_cycles++;
                req_addr = bus.bmem_addr;
                if (first_rd < 0) first_rd = cyc;
                if (stall_left > 0) stall_left--;
                else begin bus.bmem_ready = 1'b1; acc = 1'b1; beat = 0; end
            end else if (bus.bmem_write === 1'b1) begin
                if (first_wr < 0) first_wr = cyc;
                wbeats.push_back(bus.bmem_wdata);
                bus.bmem_ready = (widx < rpat_len) ? rpat[widx] : 1'b1;
                widx++;
            end else if (acc) begin
                if (beat == gap_at && gap_left > 0) begin
                    gap_left--;
                    if (bad_in_gap) begin
                        bus.bmem_rvalid = 1'b1;
                        bus.bmem_raddr  = req_addr ^ 32'h0000_0040;
                        bus.bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                end else begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_raddr  = req_addr;
                    bus.bmem_rdata  = rline[beat*BW +: BW];
                    beat++;
                    if (beat == NB) acc = 1'b0;
                end
            end
        end
        bus.dfp_read = 1'b0; bus.dfp_write = 1'b0;
        repeat (3) begin
            tick();
            bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
            if (bus.dfp_resp === 1'b1) extra_resp++;
        end
    endtask

    task automatic test_reset();
        logic [LW+AW+BW+2:0] outs;
        rst = 1'b1; bus.dfp_read = 1'b1; bus.dfp_write = 1'b0; bus.dfp_addr = 32'h0000_0123;
        bus.dfp_wdata = '0; bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr = '0; bus.bmem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            outs = {bus.dfp_rdata, bus.dfp_resp, bus.bmem_addr, bus.bmem_read, bus.bmem_write, bus.bmem_wdata};
            n_cmp++;
            if (outs !== '0) begin n_bad++; $display("FAIL reset_outs[%0d]: got %h expected 0", i, outs); end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.bmem_read, bus.bmem_addr} !== {1'b1, 32'h0000_0120}) begin
            n_bad++; $display("FAIL reset_first_req: got %b/%h expected 1/00000120", bus.bmem_read, bus.bmem_addr);
        end
        rst = 1'b1; bus.dfp_read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.bmem_read !== 1'b0) begin n_bad++; $display("FAIL reset_abort: bmem_read got %b expected 0", bus.bmem_read); end
    endtask

    task automatic test_read_zero_wait();
        logic [LW-1:0] line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        logic [LW-1:0] expv;
        bus.dfp_addr = 32'h1EC0_0024; bus.dfp_read = 1'b1;
        exp_lines.push_back(line);
        serve(1, 0, 0, 0, 16'h0000, 0, line, 1'b0);
        n_cmp++;
        if (req_addr !== 32'h1EC0_0020) begin n_bad++; $display("FAIL rd0_addr: got %h expected 1ec00020", req_addr); end
        n_cmp++;
        if (resp_cyc.size() !== 1) begin n_bad++; $display("FAIL rd0_nresp: got %0d expected 1", resp_cyc.size()); end
        expv = exp_lines.pop_front();
        if (resp_cyc.size() == 1) begin
            n_cmp++;
            if (resp_cyc[0] !== 6) begin n_bad++; $display("FAIL rd0_latency: got %0d expected 6", resp_cyc[0]); end
            n_cmp++;
            if (resp_line[0] !== expv) begin n_bad++; $display("FAIL rd0_line: got %h expected %h", resp_line[0], expv); end
        end
        n_cmp++;
        if (bus.dfp_rdata !== expv) begin n_bad++; $display("FAIL rd0_hold: got %h expected %h", bus.dfp_rdata, expv); end
        n_cmp++;
        if (rd_cycles !== 1 || extra_resp !== 0) begin
            n_bad++; $display("FAIL rd0_once: req cycles %0d extra resp %0d expected 1/0", rd_cycles, extra_resp);
        end
    endtask

    task automatic test_read_stall();
        logic [LW-1:0] line = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        logic [LW-1:0] expv;
        bus.dfp_addr = 32'h0000_0A7F; bus.dfp_read = 1'b1;
        exp_lines.push_back(line);
        serve(1, 3, 2, 2, 16'h0000, 0, line, 1'b1);
        n_cmp++;
        if (rd_cycles !== 4 || req_addr !== 32'h0000_0A60) begin
            n_bad++; $display("FAIL rd1_req_hold: got %0d cycles addr %h expected 4 / 00000a60", rd_cycles, req_addr);
        end
        n_cmp++;
        if (resp_cyc.size() !== 1 || extra_resp !== 0) begin
            n_bad++; $display("FAIL rd1_single_resp: got %0d+%0d expected 1+0", resp_cyc.size(), extra_resp);
        end
        expv = exp_lines.pop_front();
        if (resp_cyc.size() == 1) begin
            n_cmp++;
            if (resp_cyc[0] !== 11) begin n_bad++; $display("FAIL rd1_latency: got %0d expected 11", resp_cyc[0]); end
            n_cmp++;
            if (resp_line[0] !== expv) begin n_bad++; $display("FAIL rd1_line: got %h expected %h", resp_line[0], expv); end
        end
    endtask

    task automatic test_write_backpressure();
        logic [BW-1:0] a = 64'hAAAA_AAAA_AAAA_AAAA;
        logic [BW-1:0] b = 64'hBBBB_BBBB_BBBB_BBBB;
        logic [BW-1:0] c = 64'hCCCC_CCCC_CCCC_CCCC;
        logic [BW-1:0] d = 64'hDDDD_DDDD_DDDD_DDDD;
        logic [LW-1:0] held = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        logic [BW-1:0] eb;
        bus.dfp_addr = 32'h0000_4010; bus.dfp_wdata = {d, c, b, a}; bus.dfp_write = 1'b1;
        exp_beats.push_back(a); exp_beats.push_back(b); exp_beats.push_back(b);
        exp_beats.push_back(c); exp_beats.push_back(c); exp_beats.push_back(d);
        serve(1, 0, 0, 0, 16'h0035, 6, '0, 1'b0);
        n_cmp++;
        if (wbeats.size() !== 6) begin n_bad++; $display("FAIL wr_beat_cycles: got %0d expected 6", wbeats.size()); end
        for (int i = 0; i < 6; i++) begin
            eb = exp_beats.pop_front();
            if (i < wbeats.size()) begin
                n_cmp++;
                if (wbeats[i] !== eb) begin n_bad++; $display("FAIL wr_beat[%0d]: got %h expected %h", i, wbeats[i], eb); end
            end
        end
        n_cmp++;
        if (resp_cyc.size() !== 1 || extra_resp !== 0 || rd_cycles !== 0) begin
            n_bad++; $display("FAIL wr_resp_count: got %0d+%0d rd %0d expected 1+0 rd 0", resp_cyc.size(), extra_resp, rd_cycles);
        end
        if (resp_cyc.size() == 1) begin
            n_cmp++;
            if (resp_cyc[0] !== 7 || wr_on_resp !== 1'b0) begin
                n_bad++; $display("FAIL wr_latency: got %0d write_at_resp %b expected 7/0", resp_cyc[0], wr_on_resp);
            end
            n_cmp++;
            if (resp_line[0] !== held) begin n_bad++; $display("FAIL wr_rdata_held: got %h expected %h", resp_line[0], held); end
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] wl = {64'hF3F3_F3F3_F3F3_F3F3, 64'hF2F2_F2F2_F2F2_F2F2,
                             64'hF1F1_F1F1_F1F1_F1F1, 64'hF0F0_F0F0_F0F0_F0F0};
        logic [LW-1:0] rl = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                             64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
        logic [LW-1:0] e0, e1;
        logic [BW-1:0] eb;
        bus.dfp_addr = 32'h0000_1040; bus.dfp_wdata = wl; bus.dfp_write = 1'b1; bus.dfp_read = 1'b1;
        for (int i = 0; i < NB; i++) exp_beats.push_back(wl[i*BW +: BW]);
        exp_lines.push_back({64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                             64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        exp_lines.push_back(rl);
        serve(2, 0, 0, 0, 16'h0000, 0, rl, 1'b0);
        n_cmp++;
        if (resp_cyc.size() !== 2) begin n_bad++; $display("FAIL rw_nresp: got %0d expected 2", resp_cyc.size()); end
        n_cmp++;
        if (first_wr !== 1 || first_rd !== 7) begin
            n_bad++; $display("FAIL rw_order: first write %0d first read %0d expected 1/7", first_wr, first_rd);
        end
        for (int i = 0; i < NB; i++) begin
            eb = exp_beats.pop_front();
            n_cmp++;
            if (i >= wbeats.size() || wbeats[i] !== eb) begin
                n_bad++; $display("FAIL rw_beat[%0d]: got %h expected %h", i, (i < wbeats.size()) ? wbeats[i] : 64'h0, eb);
            end
        end
        e0 = exp_lines.pop_front();
        e1 = exp_lines.pop_front();
        if (resp_cyc.size() == 2) begin
            n_cmp++;
            if (resp_cyc[0] !== 5 || resp_cyc[1] !== 12) begin
                n_bad++; $display("FAIL rw_latency: got %0d/%0d expected 5/12", resp_cyc[0], resp_cyc[1]);
            end
            n_cmp++;
            if (resp_line[0] !== e0 || resp_line[1] !== e1) begin
                n_bad++; $display("FAIL rw_lines: got %h / %h expected %h / %h", resp_line[0], resp_line[1], e0, e1);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [LW-1:0] fresh = {64'h0DD3_0DD3_0DD3_0DD3, 64'h0DD2_0DD2_0DD2_0DD2,
                                64'h0DD1_0DD1_0DD1_0DD1, 64'h0DD0_0DD0_0DD0_0DD0};
        logic [LW+AW+BW+2:0] outs;
        logic [LW-1:0] expv;
        int stray = 0;
        bus.dfp_addr = 32'h0000_2000; bus.dfp_read = 1'b1;
        tick();
        n_cmp++;
        if (bus.bmem_read !== 1'b1) begin n_bad++; $display("FAIL mid_req: got %b expected 1", bus.bmem_read); end
        bus.bmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr = 32'h0000_2000; bus.bmem_rdata = 64'h9000_0000_0000_0000 + 64'(i);
        end
        tick();
        bus.bmem_rvalid = 1'b0; rst = 1'b1; bus.dfp_read = 1'b0;
        tick();
        rst = 1'b0;
        outs = {bus.dfp_rdata, bus.dfp_resp, bus.bmem_addr, bus.bmem_read, bus.bmem_write, bus.bmem_wdata};
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL mid_reset_outs: got %h expected 0", outs); end
        for (int i = 0; i < 4; i++) begin
            bus.bmem_rvalid = (i < 2); bus.bmem_raddr = 32'h0000_2000;
            bus.bmem_rdata = 64'h9000_0000_0000_0003 + 64'(i);
            tick();
            if (bus.dfp_resp !== 1'b0 || bus.bmem_read !== 1'b0) stray++;
        end
        bus.bmem_rvalid = 1'b0;
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL mid_stale_ignored: got %0d active cycles expected 0", stray); end
        bus.dfp_addr = 32'h0000_2000; bus.dfp_read = 1'b1;
        exp_lines.push_back(fresh);
        serve(1, 0, 0, 0, 16'h0000, 0, fresh, 1'b0);
        expv = exp_lines.pop_front();
        n_cmp++;
        if (resp_cyc.size() !== 1 || extra_resp !== 0) begin
            n_bad++; $display("FAIL mid_fresh_nresp: got %0d+%0d expected 1+0", resp_cyc.size(), extra_resp);
        end
        if (resp_cyc.size() == 1) begin
            n_cmp++;
            if (resp_line[0] !== expv || resp_cyc[0] !== 6) begin
                n_bad++; $display("FAIL mid_fresh_line: got %h at %0d expected %h at 6", resp_line[0], resp_cyc[0], expv);
            end
        end
`ifdef CLADAPT_STATS_EN
        n_cmp++;
        if (rd_lines !== 32'd1 || wr_lines !== 32'd0) begin
            n_bad++; $display("FAIL stats: rd_lines %0d wr_lines %0d expected 1/0", rd_lines, wr_lines);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_read_stall();
        test_write_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
